// File: rtl/race_top.sv
// -----------------------------------------------------------------------------
// race_top -- complex adaptive line enhancer / narrowband canceller.
//
// Predicts the current complex sample x[n] from delayed past samples
// x[n-DELAY-k], k = 0..TAPS-1, with a complex LMS FIR. The prediction error
// e = x[n] - y is the output, so predictable (narrowband) content is removed.
// One sample is processed per strobe period, time-multiplexed over the
// system clock:
//   step 0            strobe rise: capture x[n] (if valid_in), clear acc
//   steps 1..TAPS     one complex MAC per clk
//   step TAPS+1       saturate and register e, set valid_out
//   steps TAPS+2..    one weight update per clk
//   step 2*TAPS+2     shift the delay line, go idle
// A strobe rise while busy restarts at step 0 and abandons the current sample.
// Requires DELAY >= 1 and 2*TAPS+3 <= strobe period in clk cycles.
//
// Ports:
//   clk        system clock, rising edge
//   nrst       asynchronous active-low reset
//   strobe     sample-rate square wave; its rising edge starts a period
//   valid_in   input sample valid, sampled at the detected strobe rise
//   in_real    signed Q1.15 input, real part
//   in_imag    signed Q1.15 input, imaginary part
//   valid_out  out_real/out_imag hold a valid result
//   out_real   signed Q1.15 error output, real part
//   out_imag   signed Q1.15 error output, imaginary part
// -----------------------------------------------------------------------------
module race_top #(
  parameter int TAPS     = 8,
  parameter int DELAY    = 1,
  parameter int MU_SHIFT = 8,
  parameter int WW       = 18
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               strobe,
  input  logic               valid_in,
  input  logic signed [15:0] in_real,
  input  logic signed [15:0] in_imag,
  output logic               valid_out,
  output logic signed [15:0] out_real,
  output logic signed [15:0] out_imag
);

  localparam int DL    = DELAY + TAPS;            // delay-line depth
  localparam int KW    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int ACC_W = 40;                      // MAC accumulator width
  localparam int DW    = ACC_W + 1;               // error difference width
  localparam int PW    = 16 + WW + 1;             // complex MAC term width
  localparam int UW    = 33;                      // e * conj(x) term width
  localparam int NW    = UW + 1;                  // weight sum before saturation
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_ERR, S_UPD, S_SHIFT} state_t;

  function automatic logic signed [15:0] sat16(input logic signed [DW-1:0] v);
    if (v[DW-1:15] == {(DW-15){v[DW-1]}}) return v[15:0];
    return v[DW-1] ? 16'sh8000 : 16'sh7fff;
  endfunction

  function automatic logic signed [WW-1:0] sat_w(input logic signed [NW-1:0] v);
    if (v[NW-1:WW-1] == {(NW-WW+1){v[NW-1]}}) return v[WW-1:0];
    return v[NW-1] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
  endfunction

  state_t                   state, state_nx;
  logic [KW-1:0]            k, k_nx;          // tap index within MAC/UPD phases
  logic                     strobe_d, rise;
  logic signed [15:0]       x_re, x_im;       // captured x[n]
  logic signed [ACC_W-1:0]  acc_re, acc_im;
  logic signed [15:0]       dl_re [DL];       // dl[i] = x[n-1-i]
  logic signed [15:0]       dl_im [DL];
  logic signed [WW-1:0]     w_re [TAPS];
  logic signed [WW-1:0]     w_im [TAPS];

  logic signed [15:0]       tap_re, tap_im;   // x[n-DELAY-k]
  logic signed [WW-1:0]     ws_re, ws_im;     // w_k
  logic signed [PW-1:0]     mac_re, mac_im;
  logic signed [DW-1:0]     diff_re, diff_im;
  logic signed [15:0]       e_re, e_im;
  logic signed [UW-1:0]     upd_re, upd_im;
  logic signed [WW-1:0]     wn_re, wn_im;

  assign rise = strobe & ~strobe_d;

  // ---------------------------------------------------------------------------
  // Sequencer: next state
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    if (rise) begin
      k_nx     = '0;
      state_nx = valid_in ? S_MAC : S_IDLE;
    end else begin
      case (state)
        S_MAC: begin
          if (k == K_LAST) begin
            k_nx     = '0;
            state_nx = S_ERR;
          end else begin
            k_nx = k + 1'b1;
          end
        end
        S_ERR: state_nx = S_UPD;
        S_UPD: begin
          if (k == K_LAST) begin
            k_nx     = '0;
            state_nx = S_SHIFT;
          end else begin
            k_nx = k + 1'b1;
          end
        end
        S_SHIFT: state_nx = S_IDLE;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= S_IDLE;
      k        <= '0;
      strobe_d <= 1'b0;
    end else begin
      state    <= state_nx;
      k        <= k_nx;
      strobe_d <= strobe;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath arithmetic (shared tap select for MAC and weight update)
  // ---------------------------------------------------------------------------
  always_comb begin
    tap_re = '0;
    tap_im = '0;
    ws_re  = '0;
    ws_im  = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (k == KW'(i)) begin
        tap_re = dl_re[DELAY-1+i];
        tap_im = dl_im[DELAY-1+i];
        ws_re  = w_re[i];
        ws_im  = w_im[i];
      end
    end
  end

  // y += w_k * x_k
  assign mac_re = PW'(tap_re) * PW'(ws_re) - PW'(tap_im) * PW'(ws_im);
  assign mac_im = PW'(tap_re) * PW'(ws_im) + PW'(tap_im) * PW'(ws_re);

  // e = x[n] - (y >>> 15)
  assign diff_re = DW'(x_re) - DW'(acc_re >>> 15);
  assign diff_im = DW'(x_im) - DW'(acc_im >>> 15);
  assign e_re    = sat16(diff_re);
  assign e_im    = sat16(diff_im);

  // e * conj(x_k); e is the registered output value during the update phase
  assign upd_re = UW'(out_real) * UW'(tap_re) + UW'(out_imag) * UW'(tap_im);
  assign upd_im = UW'(out_imag) * UW'(tap_re) - UW'(out_real) * UW'(tap_im);
  assign wn_re  = sat_w(NW'(ws_re) + NW'(upd_re >>> (15 + MU_SHIFT)));
  assign wn_im  = sat_w(NW'(ws_im) + NW'(upd_im >>> (15 + MU_SHIFT)));

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the delay line and weights are small register arrays that must start
  // from zero, so they sit on the async reset like ordinary state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_re      <= '0;
      x_im      <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      valid_out <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      for (int i = 0; i < DL; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
      for (int i = 0; i < TAPS; i++) begin
        w_re[i] <= '0;
        w_im[i] <= '0;
      end
    end else if (rise) begin
      if (valid_in) begin
        x_re   <= in_real;
        x_im   <= in_imag;
        acc_re <= '0;
        acc_im <= '0;
      end else begin
        valid_out <= 1'b0;
      end
    end else begin
      case (state)
        S_MAC: begin
          acc_re <= acc_re + ACC_W'(mac_re);
          acc_im <= acc_im + ACC_W'(mac_im);
        end
        S_ERR: begin
          out_real  <= e_re;
          out_imag  <= e_im;
          valid_out <= 1'b1;
        end
        S_UPD: begin
          w_re[k] <= wn_re;
          w_im[k] <= wn_im;
        end
        S_SHIFT: begin
          for (int i = DL - 1; i > 0; i--) begin
            dl_re[i] <= dl_re[i-1];
            dl_im[i] <= dl_im[i-1];
          end
          dl_re[0] <= x_re;
          dl_im[0] <= x_im;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_race_top.sv
// -----------------------------------------------------------------------------
// tb_race_top -- self-checking bench for race_top.
//
// Two instances share all stimulus: u_slow with the default step size and
// u_fast with MU_SHIFT=0 (fast convergence, drives weights into saturation).
// A behavioural complex-LMS model per instance, built from plain integer
// arithmetic on arrays, predicts every output. The strobe mimics the
// clock_divider output: period 20 clks, high for 10.
// -----------------------------------------------------------------------------
module tb_race_top;

  localparam int TAPS  = 8;
  localparam int DELAY = 1;
  localparam int WW    = 18;
  localparam int DL    = DELAY + TAPS;
  localparam int PER   = 20;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              strobe = 1'b0;
  logic              valid_in = 1'b0;
  logic [15:0]       in_real = '0;
  logic [15:0]       in_imag = '0;
  logic [1:0]        vout;
  logic [1:0][15:0]  ore;
  logic [1:0][15:0]  oim;

  always #5 clk = ~clk;

  race_top #(.TAPS(TAPS), .DELAY(DELAY), .MU_SHIFT(8), .WW(WW)) u_slow (
    .clk(clk), .nrst(nrst), .strobe(strobe), .valid_in(valid_in),
    .in_real(in_real), .in_imag(in_imag),
    .valid_out(vout[0]), .out_real(ore[0]), .out_imag(oim[0])
  );

  race_top #(.TAPS(TAPS), .DELAY(DELAY), .MU_SHIFT(0), .WW(WW)) u_fast (
    .clk(clk), .nrst(nrst), .strobe(strobe), .valid_in(valid_in),
    .in_real(in_real), .in_imag(in_imag),
    .valid_out(vout[1]), .out_real(ore[1]), .out_imag(oim[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: y = sum w_k x[n-DELAY-k]; e = sat(x - y/2^15);
  // w_k = sat(w_k + e*conj(x_k) / 2^(15+mu)) with floor division.
  // ---------------------------------------------------------------------------
  longint mw_re [2][TAPS];
  longint mw_im [2][TAPS];
  longint mh_re [2][DL];     // mh[i] = x[n-1-i]
  longint mh_im [2][DL];
  longint mo_re [2];
  longint mo_im [2];
  bit     mv    [2];

  function automatic longint sat(input longint v, input int bits);
    longint hi = (longint'(1) << (bits - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < TAPS; i++) begin mw_re[m][i] = 0; mw_im[m][i] = 0; end
      for (int i = 0; i < DL; i++)   begin mh_re[m][i] = 0; mh_im[m][i] = 0; end
      mo_re[m] = 0; mo_im[m] = 0; mv[m] = 0;
    end
  endfunction

  function automatic void model_step(input int m, input bit v, input longint xr, input longint xi);
    longint yr = 0, yi = 0, er, ei, tr, ti, dr, di;
    int mu = (m == 0) ? 8 : 0;
    if (!v) begin
      mv[m] = 0;
      return;
    end
    for (int k = 0; k < TAPS; k++) begin
      tr = mh_re[m][DELAY-1+k];
      ti = mh_im[m][DELAY-1+k];
      yr += mw_re[m][k] * tr - mw_im[m][k] * ti;
      yi += mw_re[m][k] * ti + mw_im[m][k] * tr;
    end
    er = sat(xr - (yr >>> 15), 16);
    ei = sat(xi - (yi >>> 15), 16);
    for (int k = 0; k < TAPS; k++) begin
      tr = mh_re[m][DELAY-1+k];
      ti = mh_im[m][DELAY-1+k];
      dr = er * tr + ei * ti;
      di = ei * tr - er * ti;
      mw_re[m][k] = sat(mw_re[m][k] + (dr >>> (15 + mu)), WW);
      mw_im[m][k] = sat(mw_im[m][k] + (di >>> (15 + mu)), WW);
    end
    for (int i = DL - 1; i > 0; i--) begin
      mh_re[m][i] = mh_re[m][i-1];
      mh_im[m][i] = mh_im[m][i-1];
    end
    mh_re[m][0] = xr;
    mh_im[m][0] = xi;
    mo_re[m] = er;
    mo_im[m] = ei;
    mv[m]    = 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic longint rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return longint'(t);
  endfunction

  function automatic longint qtab(input int i);
    case (i)
      0:       return 8192;
      1:       return 7568;
      2:       return 5793;
      3:       return 3135;
      default: return 0;
    endcase
  endfunction

  // 0x2000 * cos(2*pi*k/16)
  function automatic longint tone_cos(input int k);
    int q = k % 16;
    if (q <= 4)  return qtab(q);
    if (q <= 8)  return -qtab(8 - q);
    if (q <= 12) return -qtab(q - 8);
    return qtab(16 - q);
  endfunction

  function automatic longint tone_sin(input int k);
    return tone_cos(k + 12);
  endfunction

  // One strobe period. Entered #1 after a rising edge with strobe low; the
  // next edge (c == 0) is the rise clk. The result must appear after edge
  // TAPS+1 (the (TAPS+2)-th edge counting the rise clk) and not before.
  task automatic do_sample(input bit v, input longint xr, input longint xi);
    longint pr [2];
    longint pi [2];
    bit     pv [2];
    for (int m = 0; m < 2; m++) begin
      pr[m] = mo_re[m]; pi[m] = mo_im[m]; pv[m] = mv[m];
      model_step(m, v, xr, xi);
    end
    strobe   = 1'b1;
    valid_in = v;
    in_real  = 16'(xr);
    in_imag  = 16'(xi);
    for (int c = 0; c < PER; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        // inputs are only looked at on the rise clk
        valid_in = 1'($urandom);
        in_real  = 16'($urandom);
        in_imag  = 16'($urandom);
      end
      if (v && c == TAPS) begin
        for (int m = 0; m < 2; m++) begin
          check($sformatf("early_valid[%0d]", m), vout[m], pv[m]);
          check($sformatf("early_re[%0d]", m), $signed(ore[m]), pr[m]);
          check($sformatf("early_im[%0d]", m), $signed(oim[m]), pi[m]);
        end
      end
      if (c == TAPS + 1) begin
        for (int m = 0; m < 2; m++) begin
          check($sformatf("valid[%0d]", m), vout[m], mv[m]);
          check($sformatf("out_re[%0d]", m), $signed(ore[m]), mo_re[m]);
          check($sformatf("out_im[%0d]", m), $signed(oim[m]), mo_im[m]);
        end
      end
      if (c == PER / 2 - 1) strobe = 1'b0;
    end
  endtask

  // Async reset while the sequencer is at step 5, then one sample that must
  // reproduce its input because all weights are back at zero.
  task automatic reset_mid();
    longint xr, xi;
    strobe   = 1'b1;
    valid_in = 1'b1;
    in_real  = 16'h1234;
    in_imag  = 16'hedcb;
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk);
      #1;
    end
    nrst = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst_mid_valid[%0d]", m), vout[m], 0);
      check($sformatf("rst_mid_re[%0d]", m), $signed(ore[m]), 0);
      check($sformatf("rst_mid_im[%0d]", m), $signed(oim[m]), 0);
    end
    strobe   = 1'b0;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    xr = rnd16();
    xi = rnd16();
    do_sample(1'b1, xr, xi);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("post_rst_re[%0d]", m), $signed(ore[m]), xr);
      check($sformatf("post_rst_im[%0d]", m), $signed(oim[m]), xi);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    longint ar, ai;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst_valid[%0d]", m), vout[m], 0);
      check($sformatf("rst_re[%0d]", m), $signed(ore[m]), 0);
      check($sformatf("rst_im[%0d]", m), $signed(oim[m]), 0);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // zero weights: first sample passes straight through
    do_sample(1'b1, 64'sh4000, 64'sh0);
    check("first_re", $signed(ore[0]), 16'sh4000);
    check("first_im", $signed(oim[0]), 0);
    check("first_valid", vout[0], 1);

    // random full-scale samples with occasional invalid periods
    for (int n = 0; n < 200; n++)
      do_sample($urandom_range(0, 9) != 0, rnd16(), rnd16());

    // explicit 10-period gap, then the stream continues
    for (int n = 0; n < 10; n++)
      do_sample(1'b0, rnd16(), rnd16());
    for (int n = 0; n < 20; n++)
      do_sample(1'b1, rnd16(), rnd16());

    // learn +A,-A,+A..., then break the pattern: error exceeds full scale
    for (int n = 0; n <= 300; n++)
      do_sample(1'b1, (n % 2 == 0) ? 64'sd32767 : -64'sd32767, 64'sd0);
    do_sample(1'b1, 64'sd32767, 64'sd0);
    check("sat_out_re", $signed(ore[0]), 32767);

    reset_mid();

    // complex tone at fs/16, amplitude 0x2000
    for (int n = 0; n < 1500; n++) begin
      do_sample(1'b1, tone_cos(n), tone_sin(n));
      if (n >= 1500 - 16) begin
        ar = $signed(ore[1]);
        ai = $signed(oim[1]);
        if (ar < 0) ar = -ar;
        if (ai < 0) ai = -ai;
        check("tone_floor", longint'(ar < 256 && ai < 256), 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
